// File: rtl/outfifo_pingpong_if.sv
// outfifo_pingpong_if
//   Bundles the write-side and read-side handshake signals of the ping-pong
//   output FIFO.
//   master : upstream unload logic plus downstream consumer; drives writes,
//            commits, frame length and out_ready
//   slave  : the FIFO itself; drives wr_ready, the output word stream and
//            the status flags
//   Signals:
//     wr_en, wr_addr, wr_data, wr_commit, frame_len   (master -> slave)
//     wr_ready                                        (slave -> master)
//     out_valid, out_data, out_last, frame_done       (slave -> master)
//     out_ready                                       (master -> slave)
//     bank_full, err_overflow                         (slave -> master)
interface outfifo_pingpong_if #(
    parameter int KB   = 14,
    parameter int HDDW = 32,
    parameter int AW   = 5,
    parameter int LENW = 9
);
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [KB*HDDW-1:0]   wr_data;
    logic                 wr_commit;
    logic [LENW-1:0]      frame_len;
    logic                 wr_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [HDDW-1:0]      out_data;
    logic                 out_last;
    logic                 frame_done;
    logic [1:0]           bank_full;
    logic                 err_overflow;

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit, frame_len, out_ready,
        input  wr_ready, out_valid, out_data, out_last, frame_done,
               bank_full, err_overflow
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit, frame_len, out_ready,
        output wr_ready, out_valid, out_data, out_last, frame_done,
               bank_full, err_overflow
    );
endinterface

// File: rtl/outfifo_pingpong.sv
// outfifo_pingpong
//   Double-buffered decoder output FIFO. Upstream fills one bank KB words
//   per write and commits it with a frame length; the reader streams the
//   committed frame one HDDW word per handshake while the other bank fills.
//   Ports:
//     rdclk : single clock for both write and read sides
//     rst   : synchronous, active-low reset
//     bus   : outfifo_pingpong_if.slave (write bus, output stream, status)
module outfifo_pingpong #(
    parameter int KB    = 14,
    parameter int HDDW  = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int LENW  = 9
) (
    input logic               rdclk,
    input logic               rst,
    outfifo_pingpong_if.slave bus
);

    localparam int              CW      = (KB > 1) ? $clog2(KB) : 1;
    localparam logic [CW-1:0]   COL_MAX = CW'(KB - 1);
    localparam logic [LENW-1:0] MAX_LEN = LENW'(KB * DEPTH);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Storage: bank x column (sub-memory) x row
    logic [HDDW-1:0] mem [2][KB][DEPTH];

    // Write-side state
    logic            wrPtr_q;
    logic [1:0]      bankFull_q;
    logic [LENW-1:0] len_q [2];
    logic            errOverflow_q;

    // Reader state
    state_t          state_q;
    logic            rdPtr_q;
    logic [CW-1:0]   col_q;
    logic [AW-1:0]   row_q;
    logic [LENW-1:0] idx_q;
    logic [HDDW-1:0] outData_q;
    logic            outValid_q;
    logic            outLast_q;
    logic            frameDone_q;

    // Combinational helpers
    logic            wrReady;
    logic            wrAccept;
    logic            commitAccept;
    logic            illegalOp;
    logic [LENW-1:0] clampedLen;
    logic            load;
    logic            isLastWord;
    logic            lastLoad;
    logic [1:0]      setMask_d;
    logic [1:0]      clrMask_d;
    logic [1:0]      bankFull_d;
    logic [HDDW-1:0] readWord;

    // Write-side qualification. A zero-length commit is treated like a
    // commit into a busy bank: dropped and flagged, though a write issued in
    // the same cycle still lands.
    always_comb begin
        wrReady      = ~bankFull_q[wrPtr_q];
        wrAccept     = bus.wr_en && wrReady;
        commitAccept = bus.wr_commit && wrReady && (bus.frame_len != '0);
        illegalOp    = ((bus.wr_en || bus.wr_commit) && !wrReady)
                     || (bus.wr_commit && wrReady && (bus.frame_len == '0));
        clampedLen   = (bus.frame_len > MAX_LEN) ? MAX_LEN : bus.frame_len;
    end

    // Reader load decision. In STREAM there is always at least one word
    // left, because the FSM leaves or re-targets the moment the last word
    // of a frame is loaded.
    always_comb begin
        load       = (state_q == STREAM) && (!outValid_q || bus.out_ready);
        isLastWord = (idx_q == (len_q[rdPtr_q] - LENW'(1)));
        lastLoad   = load && isLastWord;
        readWord   = mem[rdPtr_q][col_q][row_q];
    end

    // Full flags are set by commits and cleared by the reader. The two can
    // never target the same bank in one cycle: a commit needs its bank empty
    // while a release needs its bank full.
    always_comb begin
        setMask_d            = 2'b00;
        clrMask_d            = 2'b00;
        setMask_d[wrPtr_q]   = commitAccept;
        clrMask_d[rdPtr_q]   = lastLoad;
        bankFull_d           = (bankFull_q | setMask_d) & ~clrMask_d;
    end

    // Memory write port; contents survive reset on purpose.
    always_ff @(posedge rdclk) begin
        if (wrAccept) begin
            for (int c = 0; c < KB; c++) begin
                mem[wrPtr_q][c][bus.wr_addr] <= bus.wr_data[c*HDDW +: HDDW];
            end
        end
    end

    // Write pointer, per-bank frame lengths, full flags and the sticky error.
    always_ff @(posedge rdclk) begin
        if (!rst) begin
            wrPtr_q       <= 1'b0;
            bankFull_q    <= 2'b00;
            len_q[0]      <= '0;
            len_q[1]      <= '0;
            errOverflow_q <= 1'b0;
        end else begin
            bankFull_q <= bankFull_d;
            if (commitAccept) begin
                len_q[wrPtr_q] <= clampedLen;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (illegalOp) begin
                errOverflow_q <= 1'b1;
            end
        end
    end

    // Reader FSM with registered output word. Column/row counters walk the
    // frame in index order (column fastest) so no divider is needed. On the
    // last load the bank is released and, if the other bank is already
    // full, streaming continues from its word 0 without a bubble.
    always_ff @(posedge rdclk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rdPtr_q     <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            idx_q       <= '0;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            frameDone_q <= outValid_q && bus.out_ready && outLast_q;

            if (load) begin
                outData_q  <= readWord;
                outValid_q <= 1'b1;
                outLast_q  <= isLastWord;
            end else if (outValid_q && bus.out_ready) begin
                outValid_q <= 1'b0;
                outLast_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bankFull_q[rdPtr_q]) begin
                        state_q <= STREAM;
                        col_q   <= '0;
                        row_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                STREAM: begin
                    if (load) begin
                        if (isLastWord) begin
                            rdPtr_q <= ~rdPtr_q;
                            col_q   <= '0;
                            row_q   <= '0;
                            idx_q   <= '0;
                            state_q <= bankFull_q[~rdPtr_q] ? STREAM : IDLE;
                        end else begin
                            idx_q <= idx_q + LENW'(1);
                            if (col_q == COL_MAX) begin
                                col_q <= '0;
                                row_q <= row_q + AW'(1);
                            end else begin
                                col_q <= col_q + CW'(1);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready     = wrReady;
    assign bus.out_valid    = outValid_q;
    assign bus.out_data     = outData_q;
    assign bus.out_last     = outLast_q;
    assign bus.frame_done   = frameDone_q;
    assign bus.bank_full    = bankFull_q;
    assign bus.err_overflow = errOverflow_q;

endmodule

// File: tb/tb_outfifo_pingpong.sv
// tb_outfifo_pingpong
//   Scoreboard bench for outfifo_pingpong. Commits push the expected word
//   stream into a queue; an independent monitor pops and compares on every
//   output handshake, and also checks that a stalled word holds steady.
module tb_outfifo_pingpong;

    localparam int KB    = 14;
    localparam int HDDW  = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int LENW  = 9;

    typedef struct packed {
        logic [HDDW-1:0] data;
        logic            last;
    } exp_t;

    logic rdclk;
    logic rst;

    outfifo_pingpong_if #(.KB(KB), .HDDW(HDDW), .AW(AW), .LENW(LENW)) bus ();

    outfifo_pingpong #(
        .KB(KB), .HDDW(HDDW), .DEPTH(DEPTH), .AW(AW), .LENW(LENW)
    ) dut (
        .rdclk (rdclk),
        .rst   (rst),
        .bus   (bus)
    );

    exp_t        expQ[$];
    exp_t        popped;
    int          checks    = 0;
    int          errors    = 0;
    int          popCount  = 0;
    int          doneCount = 0;
    int          curRun    = 0;
    int          lastRun   = 0;
    bit          readyMode = 1'b0;
    bit          readyConst = 1'b1;
    logic [3:0]  readyPat  = 4'b1001;
    int          readyCyc  = 0;
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic        prevLast  = 1'b0;
    logic [HDDW-1:0] prevData = '0;

    // Free-running clock.
    initial begin
        rdclk = 1'b0;
        forever #5 rdclk = ~rdclk;
    end

    // Downstream ready: constant, or the repeating 1,0,0,1 pattern.
    initial begin
        forever begin
            bus.out_ready = readyMode ? readyPat[readyCyc % 4] : readyConst;
            @(posedge rdclk);
            #1;
            readyCyc++;
        end
    end

    // Monitor: on each falling edge, pop/compare accepted words, check stall
    // stability, count frame_done pulses and track runs of valid cycles.
    initial begin
        forever begin
            @(negedge rdclk);
            if (rst) begin
                if (prevValid && !prevReady) begin
                    checks++;
                    if (!(bus.out_valid && bus.out_data == prevData && bus.out_last == prevLast)) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: got valid=%0b data=%0d last=%0b, want valid=1 data=%0d last=%0b",
                                 bus.out_valid, bus.out_data, bus.out_last, prevData, prevLast);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    popCount++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_word: got data=%0d last=%0b, want no word",
                                 bus.out_data, bus.out_last);
                    end else begin
                        popped = expQ.pop_front();
                        if (bus.out_data !== popped.data || bus.out_last !== popped.last) begin
                            errors++;
                            $display("[TB] FAIL word: got data=%0d last=%0b, want data=%0d last=%0b",
                                     bus.out_data, bus.out_last, popped.data, popped.last);
                        end
                    end
                end
                if (bus.frame_done) doneCount++;
                if (bus.out_valid) begin
                    curRun++;
                end else if (curRun != 0) begin
                    lastRun = curRun;
                    curRun  = 0;
                end
                prevValid = bus.out_valid;
                prevReady = bus.out_ready;
                prevData  = bus.out_data;
                prevLast  = bus.out_last;
            end else begin
                prevValid = 1'b0;
                curRun    = 0;
            end
        end
    end

    // One compare with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Drive one write-bus cycle; called just after a rising edge.
    task automatic applyStimulus(input logic en, input logic [AW-1:0] addr,
                                 input logic [KB*HDDW-1:0] data, input logic commit,
                                 input logic [LENW-1:0] len);
        bus.wr_en     = en;
        bus.wr_addr   = addr;
        bus.wr_data   = data;
        bus.wr_commit = commit;
        bus.frame_len = len;
        @(posedge rdclk);
        #1;
        bus.wr_en     = 1'b0;
        bus.wr_commit = 1'b0;
    endtask

    function automatic logic [KB*HDDW-1:0] rowData(input int base, input int a);
        logic [KB*HDDW-1:0] d;
        d = '0;
        for (int c = 0; c < KB; c++) d[c*HDDW +: HDDW] = HDDW'(base + a*KB + c);
        return d;
    endfunction

    task automatic pushFrame(input int base, input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.data = HDDW'(base + i);
            e.last = (i == len - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic writeRows(input int base, input int nrows);
        for (int a = 0; a < nrows; a++) applyStimulus(1'b1, AW'(a), rowData(base, a), 1'b0, '0);
    endtask

    // Commit and record the expected stream (length clamped to the bank size).
    task automatic commitFrame(input int base, input int len);
        int eff;
        applyStimulus(1'b0, '0, '0, 1'b1, LENW'(len));
        eff = (len > KB*DEPTH) ? KB*DEPTH : len;
        if (eff > 0) pushFrame(base, eff);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge rdclk);
            #1;
        end
    endtask

    // Wait (bounded) for the scoreboard to empty and the output to go idle.
    task automatic waitDrain(input string name);
        int k;
        k = 0;
        while ((expQ.size() != 0 || bus.out_valid) && k < 3000) begin
            @(posedge rdclk);
            #1;
            k++;
        end
        checkOutput({name, "_drain_left"}, expQ.size(), 0);
        idle(3);
    endtask

    int doneStart;
    int popStart;
    int k;

    initial begin
        rst           = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_commit = 1'b0;
        bus.frame_len = '0;
        idle(3);

        // Reset state
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_data", bus.out_data, 0);
        checkOutput("rst_last", bus.out_last, 0);
        checkOutput("rst_bank_full", bus.bank_full, 0);
        checkOutput("rst_err", bus.err_overflow, 0);
        checkOutput("rst_wr_ready", bus.wr_ready, 1);
        rst = 1'b1;
        idle(2);

        // Frame of 223 ramp words; out_valid two edges after the commit edge
        $display("[TB] frame len 223");
        doneStart = doneCount;
        writeRows(0, 16);
        commitFrame(0, 223);
        checkOutput("lat_e0", bus.out_valid, 0);
        idle(1);
        checkOutput("lat_e1", bus.out_valid, 0);
        idle(1);
        checkOutput("lat_e2", bus.out_valid, 1);
        waitDrain("f223");
        checkOutput("f223_done", doneCount - doneStart, 1);

        // Back-to-back frames, second written and committed in one cycle
        $display("[TB] back-to-back 10 + 5");
        doneStart = doneCount;
        writeRows(100, 1);
        commitFrame(100, 10);
        applyStimulus(1'b1, '0, rowData(200, 0), 1'b1, LENW'(5));
        pushFrame(200, 5);
        waitDrain("b2b");
        checkOutput("b2b_run", lastRun, 15);
        checkOutput("b2b_done", doneCount - doneStart, 2);

        // Backpressure pattern 1,0,0,1
        $display("[TB] backpressure len 30");
        doneStart = doneCount;
        readyMode = 1'b1;
        writeRows(3000, 3);
        commitFrame(3000, 30);
        waitDrain("bp");
        readyMode = 1'b0;
        checkOutput("bp_done", doneCount - doneStart, 1);

        // Both banks full: write and commit are ignored and flagged
        $display("[TB] overflow");
        doneStart  = doneCount;
        readyConst = 1'b0;
        writeRows(1000, 1);
        commitFrame(1000, 14);
        writeRows(2000, 1);
        commitFrame(2000, 8);
        idle(2);
        checkOutput("ovf_full", bus.bank_full, 3);
        checkOutput("ovf_wr_ready", bus.wr_ready, 0);
        checkOutput("ovf_err_before", bus.err_overflow, 0);
        applyStimulus(1'b1, '0, rowData(9000, 0), 1'b0, '0);
        checkOutput("ovf_err_write", bus.err_overflow, 1);
        applyStimulus(1'b0, '0, '0, 1'b1, LENW'(5));
        checkOutput("ovf_full_after", bus.bank_full, 3);
        readyConst = 1'b1;
        waitDrain("ovf");
        checkOutput("ovf_done", doneCount - doneStart, 2);
        checkOutput("ovf_err_sticky", bus.err_overflow, 1);

        // Reset mid-stream at word 7
        $display("[TB] reset mid-stream");
        writeRows(6000, 2);
        commitFrame(6000, 20);
        popStart = popCount;
        k = 0;
        while (popCount < popStart + 7 && k < 200) begin
            idle(1);
            k++;
        end
        checkOutput("mid_reached7", (popCount >= popStart + 7), 1);
        rst = 1'b0;
        idle(1);
        checkOutput("mid_valid", bus.out_valid, 0);
        checkOutput("mid_data", bus.out_data, 0);
        checkOutput("mid_last", bus.out_last, 0);
        checkOutput("mid_done", bus.frame_done, 0);
        checkOutput("mid_bank_full", bus.bank_full, 0);
        checkOutput("mid_err", bus.err_overflow, 0);
        expQ.delete();
        rst = 1'b1;
        idle(2);
        doneStart = doneCount;
        writeRows(4000, 1);
        commitFrame(4000, 12);
        waitDrain("post_rst");
        checkOutput("post_rst_done", doneCount - doneStart, 1);

        // Zero-length commit is dropped and flagged
        $display("[TB] zero length and clamp");
        checkOutput("zero_err_before", bus.err_overflow, 0);
        commitFrame(7000, 0);
        checkOutput("zero_err", bus.err_overflow, 1);
        checkOutput("zero_bank_full", bus.bank_full, 0);
        checkOutput("zero_wr_ready", bus.wr_ready, 1);
        idle(4);
        checkOutput("zero_no_valid", bus.out_valid, 0);

        // Oversized length clamps to the full bank
        doneStart = doneCount;
        popStart  = popCount;
        writeRows(5000, DEPTH);
        commitFrame(5000, 500);
        waitDrain("clamp");
        checkOutput("clamp_words", popCount - popStart, KB*DEPTH);
        checkOutput("clamp_done", doneCount - doneStart, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/outfifo_pingpong.md
Name: outfifo_pingpong

Overview:
- Parametrised, double-buffered successor to the decoder output FIFO.
- Upstream unload logic writes a decoded frame of up to KB*DEPTH words of HDDW bits into one bank, KB words per write, then commits it.
- A reader streams the committed frame out one HDDW word per handshake under valid/ready backpressure while the other bank fills.
- Frame length is set per frame, replacing the fixed 223-cycle count.

Parameters:
KB, 14, words written per write (block columns); sub-memories per bank
HDDW, 32, output word width in bits
DEPTH, 32, rows per sub-memory
AW, 5, row address width, clog2(DEPTH)
LENW, 9, frame length width, clog2(KB*DEPTH+1)

Ports:
rdclk  in  1  single clock for the write and read sides; upstream crosses domains before this block
rst  in  1  synchronous, active-low reset
wr_en  in  1  write KB words at row wr_addr of the write bank
wr_addr  in  AW  row address
wr_data  in  KB*HDDW  word c is bits [(c+1)*HDDW-1 : c*HDDW]
wr_commit  in  1  marks the write bank full
frame_len  in  LENW  word count of the frame being committed; sampled with wr_commit
wr_ready  out  1  the write bank is free; gates upstream unload
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts the word
out_data  out  HDDW  output word
out_last  out  1  the current word is the last word of its frame
frame_done  out  1  one-cycle pulse when the last word is accepted
bank_full  out  2  per-bank full flags
err_overflow  out  1  sticky illegal-write/commit flag

Behaviour:
- Reset (rst=0 at a rdclk edge): wr_ptr=0, rd_ptr=0, bank_full=0, out_valid=0, out_last=0, out_data=0, frame_done=0, err_overflow=0, FSM=IDLE, counters=0. Memory contents are not cleared. Reset mid-frame abandons both banks.
- Memory: 2 banks × KB sub-memories × DEPTH × HDDW. Synchronous write, asynchronous read.
- Write side:
  - wr_ready = ~bank_full[wr_ptr].
  - wr_en with wr_ready=1 writes all KB words at wr_addr of bank wr_ptr.
  - wr_en or wr_commit with wr_ready=0 is ignored and sets err_overflow.
  - wr_commit with wr_ready=1: len_q[wr_ptr] = frame_len, bank_full[wr_ptr] set, wr_ptr toggles. All take effect at the same edge.
  - A wr_en in the same cycle as wr_commit writes before the commit.
  - frame_len=0: commit ignored, err_overflow set. frame_len>KB*DEPTH: clamp to KB*DEPTH.
- Word order:
  - Index i maps to sub-memory c = i mod KB, row a = i div KB.
  - Implement with column and row counters. No divider.
  - Column wraps KB-1→0, incrementing the row.
- Reader FSM, states IDLE and STREAM:
  - "Load" means (!out_valid || out_ready) while words remain. On a load: out_data = mem[rd_ptr][c][a], out_valid=1, out_last=(i==len_q[rd_ptr]-1), i++.
  - IDLE → STREAM when bank_full[rd_ptr]=1, with i/c/a = 0. First word loads on the next edge, i.e. out_valid rises 2 cycles after commit.
  - STREAM, load of the last word: clear bank_full[rd_ptr], toggle rd_ptr, reset counters.
    - If the other bank is full: stay in STREAM. Its word 0 loads on the next eligible edge with no bubble.
    - Otherwise go to IDLE.
  - out_valid=1 with out_ready=0: out_data and out_last hold; counters hold.
  - out_valid && out_ready && no new load: out_valid and out_last clear.
- frame_done = registered (out_valid && out_ready && out_last).
- The freed bank shows wr_ready=1 one cycle after the last word is loaded, before it is accepted. This is safe because data is held in the output register.
- Both banks full: wr_ready=0 until a release.

Test Plan:
- Reset, then commit frame_len=223 after 16 writes of ramp data (word i = i) → out_valid at cycle commit+2; words 0..222 in order; out_last only on word 222; frame_done once.
- Two back-to-back frames (len 10 and len 5, bank 0 then 1) with out_ready=1 → 15 consecutive valid cycles, no bubble; out_last on words 9 and 14; two frame_done pulses.
- out_ready toggled 1,0,0,1 pseudo-randomly over len=30 → no word dropped or duplicated; data stable while stalled.
- Both banks full, then wr_en and wr_commit → both ignored, err_overflow=1, bank contents unchanged.
- frame_len=0 commit → ignored, err_overflow=1. frame_len=500 → clamped, 448 words streamed.
- rst=0 asserted mid-stream at word 7 → next cycle all outputs 0 and bank_full=00. A new frame then streams correctly.
